// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: frame-coherent snapshot, hex decode,
// leading-zero blanking and an anode-off guard window at the start of each digit slot.
module seg7_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_index;
  logic [15:0]   r_snap_value;
  logic [3:0]    r_snap_dp;
  logic          r_snap_blz;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  logic          w_tick;
  logic [3:0]    w_nibble;
  logic [3:0]    w_zero_from;
  logic          w_blank;
  logic          w_guard;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;
  logic [3:0]    w_an_next;

  assign w_tick   = (r_presc == PW'(CLK_DIV - 1));
  assign w_nibble = r_snap_value[{r_index, 2'b00} +: 4];
  assign w_guard  = (r_presc < PW'(BLANK_CYCLES));

  // w_zero_from[i]: nibble i and every nibble above it are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_zero
      assign w_zero_from[gi] = (r_snap_value[15:4*gi] == '0);
    end
  endgenerate

  assign w_blank = r_snap_blz && (r_index != 2'd0) && w_zero_from[r_index];

  always_comb begin
    w_seg_next = 7'h7F;
    if (!w_blank) begin
      case (w_nibble)
        4'h0: w_seg_next = 7'h40;
        4'h1: w_seg_next = 7'h79;
        4'h2: w_seg_next = 7'h24;
        4'h3: w_seg_next = 7'h30;
        4'h4: w_seg_next = 7'h19;
        4'h5: w_seg_next = 7'h12;
        4'h6: w_seg_next = 7'h02;
        4'h7: w_seg_next = 7'h78;
        4'h8: w_seg_next = 7'h00;
        4'h9: w_seg_next = 7'h10;
        4'hA: w_seg_next = 7'h08;
        4'hB: w_seg_next = 7'h03;
        4'hC: w_seg_next = 7'h46;
        4'hD: w_seg_next = 7'h21;
        4'hE: w_seg_next = 7'h06;
        default: w_seg_next = 7'h0E;
      endcase
    end
  end

  assign w_dp_next = !(r_snap_dp[r_index] && !w_blank);
  assign w_an_next = (!enable || w_guard) ? 4'hF : ~(4'b0001 << r_index);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_index      <= 2'd0;
      r_snap_value <= 16'h0000;
      r_snap_dp    <= 4'h0;
      r_snap_blz   <= 1'b0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= 4'hF;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_index <= r_index + 2'd1;
        // Reload only at the frame boundary so a frame never mixes two values.
        if (r_index == 2'd3) begin
          r_snap_value <= value;
          r_snap_dp    <= dp_mask;
          r_snap_blz   <= blank_lz;
        end
      end
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model queues the
// expected outputs for every clock edge and a separate monitor pops and compares them.
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;
  logic        done = 1'b0;
  exp_t        exp_q[$];
  logic [6:0]  digit_tab [16];
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_blz;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    digit_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  // Reference model: slot position derived from elapsed cycles since reset.
  initial begin
    exp_t e;
    int   presc, idx;
    logic blank;
    m_value = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF};
        t = 0; m_value = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
      end else begin
        presc = t % CLK_DIV;
        idx   = (t / CLK_DIV) % 4;
        blank = m_blz && idx > 0 && ((m_value >> (4 * idx)) == 0);
        e.seg = blank ? 7'h7F : digit_tab[(m_value >> (4 * idx)) & 16'hF];
        e.dp  = !(m_dp[idx] && !blank);
        e.an  = (!enable || presc < BLANK) ? 4'hF : 4'(~(1 << idx));
        if (t % FRAME == FRAME - 1) begin
          m_value = value; m_dp = dp_mask; m_blz = blank_lz;
        end
        t++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per edge, compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg", int'(seg), int'(e.seg));
        check("dp",  int'(dp),  int'(e.dp));
        check("an",  int'(an),  int'(e.an));
        if ($countones(~an) > 1) check("an_onehot", int'(an), 4'hF);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cycles(n);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    cycles(1);
    do_reset(3);
    value = 16'h1234; enable = 1'b1;
    $display("phase reset+1234: 64 cycles");
    cycles(64);

    value = 16'h00F0; blank_lz = 1'b1;
    $display("phase lz blank 00F0: 64 cycles");
    cycles(64);
    value = 16'h0000;
    $display("phase lz blank 0000: 64 cycles");
    cycles(64);

    blank_lz = 1'b0; value = 16'h1111;
    cycles(FRAME * 2 + CLK_DIV + 3);
    value = 16'h8888;
    $display("phase mid-frame change 1111->8888");
    cycles(64);

    dp_mask = 4'b0101;
    $display("phase dp_mask 0101 value 8888");
    cycles(64);
    value = 16'h0000; blank_lz = 1'b1;
    $display("phase dp_mask 0101 value 0000 blank_lz");
    cycles(64);

    blank_lz = 1'b0; value = 16'h5A3C;
    cycles(FRAME + CLK_DIV + 3);
    enable = 1'b0;
    cycles(13);
    enable = 1'b1;
    $display("phase enable low 13 cycles mid-slot");
    cycles(64);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (t % FRAME == 2 * CLK_DIV + 5) found = 1'b1;
      else cycles(1);
    end
    if (!found) check("reset_sync_timeout", 0, 1);
    do_reset(1);
    $display("phase reset at presc 5 index 2");
    cycles(64);

    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 9) == 0)
        value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 14) == 0) enable = ~enable;
      reset = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    reset = 1'b0;
    $display("phase random: 1200 cycles");
    cycles(4);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #200000;
    join_any
    if (!done) check("watchdog", 0, 1);
    else begin
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) check("queue_drain", exp_q.size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
